mux_scan: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with a valid/ready output stage and two selection modes. In manual mode a port-driven select chooses the channel; in scan mode a round-robin pointer serves every requesting channel in turn. It replaces the single-bit 2:1 combinational select wherever several producers share one downstream consumer.

---
 rtl/mux_scan_pkg.sv | 15 +
 rtl/rr_pick.sv | 45 ++++
 rtl/mux_scan.sv | 115 +++++++++++
 tb/tb_mux_scan.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared definitions for the scanning multiplexer.
//   MODE_MANUAL / MODE_SCAN : encodings of the mode input.
//   next_idx(idx, n)        : successor index with explicit wrap to 0 at n-1.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Explicit wrap keeps the pointer inside 0..n-1 even when n is not a
  // power of two.
  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  : per-channel request vector
//   ptr  : channel with highest priority this cycle (must be < N)
//   any  : at least one request present
//   idx  : first requesting channel at or after ptr, wrapping through 0
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  localparam logic [SELW:0] N_W = (SELW + 1)'(N);

  logic [N-1:0]    rot;
  logic [SELW-1:0] off;
  logic [SELW:0]   idx_sum;

  // Rotate so that bit 0 of rot is the request of channel ptr; modulo-N
  // rather than modulo-2^SELW so non-power-of-two counts wrap correctly.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [SELW:0] sum;
      assign sum     = {1'b0, ptr} + (SELW + 1)'(gi);
      assign rot[gi] = req[(sum >= N_W) ? SELW'(sum - N_W) : sum[SELW-1:0]];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the winner's offset from ptr.
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = SELW'(k);
    end
  end

  assign any     = |rot;
  assign idx_sum = {1'b0, ptr} + {1'b0, off};
  assign idx     = (idx_sum >= N_W) ? SELW'(idx_sum - N_W) : idx_sum[SELW-1:0];

endmodule

// File: rtl/mux_scan.sv
// mux_scan: N-channel, W-bit registered multiplexer with valid/ready output.
//   CLK, RST   : clock (rising edge), asynchronous active-high reset
//   in_data    : N packed words, channel i at [i*W +: W]
//   in_valid   : per-channel request
//   in_ready   : one-hot accept strobe (combinational)
//   mode       : 0 = manual (sel chooses), 1 = scan (round-robin)
//   sel        : manual channel index
//   out_data   : registered selected word
//   out_ch     : registered index of the supplying channel
//   out_valid  : output register holds an unconsumed word
//   out_ready  : downstream accept
//   err_sel    : sticky, set when manual sel >= N while a load was possible
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            err_sel
);

  localparam logic [SELW:0] N_W = (SELW + 1)'(N);

  logic [W-1:0]    words [N];
  logic [W-1:0]    out_data_reg;
  logic [SELW-1:0] out_ch_reg;
  logic            out_valid_reg;
  logic            err_sel_reg;
  logic [SELW-1:0] ptr_reg;

  logic            load_ok;
  logic            sel_ok;
  logic            pick_any;
  logic [SELW-1:0] pick_idx;
  logic [SELW-1:0] chan;
  logic            take;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_words
      assign words[gi] = in_data[gi*W +: W];
    end
  endgenerate

  rr_pick #(.N(N), .SELW(SELW)) u_pick (
    .req (in_valid),
    .ptr (ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign load_ok = !out_valid_reg || out_ready;
  // sel can exceed N-1 only for non-power-of-two N.
  assign sel_ok  = ({1'b0, sel} < N_W);

  always_comb begin
    chan = pick_idx;
    take = load_ok && pick_any;
    if (mode == MODE_MANUAL) begin
      chan = sel;
      // sel_ok gates the lookup so an out-of-range sel never accepts.
      take = load_ok && sel_ok && in_valid[sel];
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = take && !RST && (chan == SELW'(gi));
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
      err_sel_reg   <= 1'b0;
    end else begin
      if (take) begin
        out_data_reg  <= words[chan];
        out_ch_reg    <= chan;
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      // Pointer advances only on scan-mode transfers and is kept across
      // mode changes.
      if (mode == MODE_SCAN && take) begin
        ptr_reg <= SELW'(next_idx(int'(pick_idx), N));
      end
      if (mode == MODE_MANUAL && !sel_ok && load_ok) begin
        err_sel_reg <= 1'b1;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;
  assign err_sel   = err_sel_reg;

endmodule

// File: tb/tb_mux_scan.sv
module tb_mux_scan;

  logic        CLK;
  logic        RST;

  // N=4 instance
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        err_sel;

  // N=3 instance
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;
  logic        err_sel3;

  int pass_cnt;
  int total_cnt;

  mux_scan #(.W(8), .N(4)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .err_sel(err_sel)
  );

  mux_scan #(.W(8), .N(3)) dut3 (
    .CLK(CLK), .RST(RST), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3),
    .err_sel(err_sel3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    // Load one word with output stalled, then reset mid-cycle.
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b0;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 8'h33) $display("FAIL reset_preload out_valid=%b out_data=%h required 1/33", out_valid, out_data);
    else pass_cnt++;
    #2 RST = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) $display("FAIL reset_async out_valid=%b out_data=%h out_ch=%0d required 0/00/0", out_valid, out_data, out_ch);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 4'b0000) $display("FAIL reset_in_ready in_ready=%b required 0000", in_ready);
    else pass_cnt++;
    in_valid = 4'b0000;
    @(negedge CLK);
    RST = 1'b0;
    tick(); tick();
    total_cnt++;
    if (out_valid !== 1'b0 || dut.ptr_reg !== 2'd0) $display("FAIL reset_idle out_valid=%b ptr=%0d required 0/0", out_valid, dut.ptr_reg);
    else pass_cnt++;
  endtask

  task automatic test_manual_sweep;
    logic [7:0] exp_data [4];
    logic [3:0] exp_rdy [4];
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      total_cnt++;
      if (in_ready !== exp_rdy[s]) $display("FAIL manual_ready sel=%0d in_ready=%b required %b", s, in_ready, exp_rdy[s]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp_data[s] || out_ch !== 2'(s)) $display("FAIL manual_out sel=%0d out_valid=%b out_data=%h out_ch=%0d required 1/%h/%0d", s, out_valid, out_data, out_ch, exp_data[s], s);
      else pass_cnt++;
    end
    total_cnt++;
    if (dut.ptr_reg !== 2'd0) $display("FAIL manual_ptr ptr=%0d required 0", dut.ptr_reg);
    else pass_cnt++;
  endtask

  task automatic test_scan_fair;
    logic [1:0] exp_all [8];
    logic [7:0] exp_dat [8];
    logic [1:0] exp_odd [4];
    exp_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_odd = '{2'd1, 2'd3, 2'd1, 2'd3};
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_ch !== exp_all[k] || out_data !== exp_dat[k]) $display("FAIL scan_all step=%0d out_valid=%b out_ch=%0d out_data=%h required 1/%0d/%h", k, out_valid, out_ch, out_data, exp_all[k], exp_dat[k]);
      else pass_cnt++;
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_ch !== exp_odd[k]) $display("FAIL scan_1010 step=%0d out_valid=%b out_ch=%0d required 1/%0d", k, out_valid, out_ch, exp_odd[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap_gaps;
    // Pointer is 0 after 1,3,1,3; a lone request on 2 moves it to 3.
    in_valid = 4'b0100;
    tick();
    total_cnt++;
    if (out_ch !== 2'd2 || dut.ptr_reg !== 2'd3) $display("FAIL wrap_setup out_ch=%0d ptr=%0d required 2/3", out_ch, dut.ptr_reg);
    else pass_cnt++;
    in_valid = 4'b0011;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0001) $display("FAIL wrap_ready0 in_ready=%b required 0001", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_ch !== 2'd0 || out_data !== 8'h11 || dut.ptr_reg !== 2'd1) $display("FAIL wrap_ch0 out_ch=%0d out_data=%h ptr=%0d required 0/11/1", out_ch, out_data, dut.ptr_reg);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 4'b0010) $display("FAIL wrap_ready1 in_ready=%b required 0010", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_ch !== 2'd1 || out_data !== 8'h22 || dut.ptr_reg !== 2'd2) $display("FAIL wrap_ch1 out_ch=%0d out_data=%h ptr=%0d required 1/22/2", out_ch, out_data, dut.ptr_reg);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    // Holding channel 1's word; stall for 5 cycles.
    out_ready = 1'b0; in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      total_cnt++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h22) $display("FAIL stall cyc=%0d in_ready=%b out_valid=%b out_ch=%0d out_data=%h required 0000/1/1/22", k, in_ready, out_valid, out_ch, out_data);
      else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 4'b0100) $display("FAIL release_ready in_ready=%b required 0100", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'h33) $display("FAIL release_load out_valid=%b out_ch=%0d out_data=%h required 1/2/33", out_valid, out_ch, out_data);
    else pass_cnt++;
    in_valid = 4'b0000;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 8'h33 || out_ch !== 2'd2) $display("FAIL drain out_valid=%b out_data=%h out_ch=%0d required 0/33/2", out_valid, out_data, out_ch);
    else pass_cnt++;
  endtask

  task automatic test_bad_sel;
    total_cnt++;
    if (err_sel3 !== 1'b0) $display("FAIL badsel_initial err_sel=%b required 0", err_sel3);
    else pass_cnt++;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b0;
    #1;
    total_cnt++;
    if (in_ready3 !== 3'b000) $display("FAIL badsel_ready in_ready=%b required 000", in_ready3);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid3 !== 1'b0 || err_sel3 !== 1'b1) $display("FAIL badsel_flag out_valid=%b err_sel=%b required 0/1", out_valid3, err_sel3);
    else pass_cnt++;
    sel3 = 2'd0;
    tick();
    total_cnt++;
    if (err_sel3 !== 1'b1 || out_valid3 !== 1'b1 || out_data3 !== 8'hA1) $display("FAIL badsel_sticky err_sel=%b out_valid=%b out_data=%h required 1/1/a1", err_sel3, out_valid3, out_data3);
    else pass_cnt++;
    in_valid3 = 3'b000;
    tick();
    RST = 1'b1;
    #1;
    total_cnt++;
    if (err_sel3 !== 1'b0) $display("FAIL badsel_clear err_sel=%b required 0", err_sel3);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    RST = 1'b1;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    in_data3  = {8'hC3, 8'hB2, 8'hA1};
    in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    test_reset();
    test_manual_sweep();
    test_scan_fair();
    test_wrap_gaps();
    test_back_to_back();
    test_bad_sel();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
